// File: rtl/ps2_ascii_decoder.sv
// PS/2 set-2 scancode to ASCII decoder with a character FIFO and a valid/ready output.
// Define PS2_CAPS_LOCK_EN to add a caps-lock toggle on make code 0x58.
module ps2_ascii_decoder #(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       rx_data,
    input  logic             read_data,
    output logic [7:0]       ascii_data,
    output logic             ascii_valid,
    input  logic             ascii_ready,
    output logic [CNT_W-1:0] fifo_count,
    output logic             overflow,
    output logic             shift_active
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

    state_t           state, state_next;
    logic             read_prev;
    logic             take;
    logic             lshift, rshift, lshift_next, rshift_next;
    logic             upper;
    logic [8:0]       map_out;
    logic             push;
    logic [7:0]       push_char;
    logic             pop, full, wr_en;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic [7:0]       mem [FIFO_DEPTH];

    // Returns {hit, char}; letters pick case from 'up', everything else from 'sh'.
    function automatic logic [8:0] key_to_ascii(input logic [7:0] code, input logic sh,
                                                input logic up);
        logic [7:0] lo, hi;
        logic       hit, letter;
        lo = 8'h00;
        hi = 8'h00;
        hit = 1'b1;
        case (code)
            8'h1C: lo = "a";  8'h32: lo = "b";  8'h21: lo = "c";  8'h23: lo = "d";
            8'h24: lo = "e";  8'h2B: lo = "f";  8'h34: lo = "g";  8'h33: lo = "h";
            8'h43: lo = "i";  8'h3B: lo = "j";  8'h42: lo = "k";  8'h4B: lo = "l";
            8'h3A: lo = "m";  8'h31: lo = "n";  8'h44: lo = "o";  8'h4D: lo = "p";
            8'h15: lo = "q";  8'h2D: lo = "r";  8'h1B: lo = "s";  8'h2C: lo = "t";
            8'h3C: lo = "u";  8'h2A: lo = "v";  8'h1D: lo = "w";  8'h22: lo = "x";
            8'h35: lo = "y";  8'h1A: lo = "z";
            8'h45: begin lo = "0"; hi = ")"; end
            8'h16: begin lo = "1"; hi = "!"; end
            8'h1E: begin lo = "2"; hi = "@"; end
            8'h26: begin lo = "3"; hi = "#"; end
            8'h25: begin lo = "4"; hi = "$"; end
            8'h2E: begin lo = "5"; hi = "%"; end
            8'h36: begin lo = "6"; hi = "^"; end
            8'h3D: begin lo = "7"; hi = "&"; end
            8'h3E: begin lo = "8"; hi = "*"; end
            8'h46: begin lo = "9"; hi = "("; end
            8'h0E: begin lo = 8'h60; hi = "~"; end
            8'h4E: begin lo = "-"; hi = "_"; end
            8'h55: begin lo = "="; hi = "+"; end
            8'h5D: begin lo = 8'h5C; hi = "|"; end
            8'h54: begin lo = "["; hi = "{"; end
            8'h5B: begin lo = "]"; hi = "}"; end
            8'h4C: begin lo = ";"; hi = ":"; end
            8'h52: begin lo = "'"; hi = "\""; end
            8'h41: begin lo = ","; hi = "<"; end
            8'h49: begin lo = "."; hi = ">"; end
            8'h4A: begin lo = "/"; hi = "?"; end
            8'h29: begin lo = " "; hi = " "; end
            8'h5A: begin lo = 8'h0D; hi = 8'h0D; end
            8'h66: begin lo = 8'h08; hi = 8'h08; end
            8'h0D: begin lo = 8'h09; hi = 8'h09; end
            8'h76: begin lo = 8'h1B; hi = 8'h1B; end
            default: hit = 1'b0;
        endcase
        letter = (lo >= "a") && (lo <= "z");
        if (letter) begin
            hi = lo - 8'h20;
            return {hit, up ? hi : lo};
        end
        return {hit, sh ? hi : lo};
    endfunction

    assign take         = read_data && !read_prev;
    assign shift_active = lshift | rshift;

`ifdef PS2_CAPS_LOCK_EN
    logic caps, caps_next;
    assign upper = shift_active ^ caps;
`else
    assign upper = shift_active;
`endif

    assign map_out = key_to_ascii(rx_data, shift_active, upper);

    always_comb begin
        state_next  = state;
        lshift_next = lshift;
        rshift_next = rshift;
`ifdef PS2_CAPS_LOCK_EN
        caps_next   = caps;
`endif
        push        = 1'b0;
        push_char   = 8'h00;
        if (take) begin
            case (state)
                IDLE: begin
                    if (rx_data == 8'hF0) begin
                        state_next = BRK;
                    end else if (rx_data == 8'hE0) begin
                        state_next = EXT;
                    end else if (rx_data == 8'hAA || rx_data == 8'hFA || rx_data == 8'hEE ||
                                 rx_data == 8'hFE || rx_data == 8'h00 || rx_data == 8'hFF) begin
                        state_next = IDLE;
                    end else if (rx_data == 8'h12) begin
                        lshift_next = 1'b1;
                    end else if (rx_data == 8'h59) begin
                        rshift_next = 1'b1;
`ifdef PS2_CAPS_LOCK_EN
                    end else if (rx_data == 8'h58) begin
                        caps_next = ~caps;
`endif
                    end else begin
                        push      = map_out[8];
                        push_char = map_out[7:0];
                    end
                end
                BRK: begin
                    if (rx_data == 8'h12) lshift_next = 1'b0;
                    if (rx_data == 8'h59) rshift_next = 1'b0;
                    state_next = IDLE;
                end
                EXT: begin
                    if (rx_data == 8'hF0) begin
                        state_next = EXT_BRK;
                    end else begin
                        state_next = IDLE;
                        if (rx_data == 8'h5A) begin
                            push      = 1'b1;
                            push_char = 8'h0D;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // FIFO: explicit count resolves full/empty; a pop frees the slot a same-cycle push needs.
    assign pop         = (count != '0) && ascii_ready;
    assign full        = (count == CNT_W'(FIFO_DEPTH));
    assign wr_en       = push && (!full || pop);
    assign ascii_valid = (count != '0);
    assign ascii_data  = ascii_valid ? mem[rd_ptr] : 8'h00;
    assign fifo_count  = count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            read_prev <= 1'b0;
            lshift    <= 1'b0;
            rshift    <= 1'b0;
`ifdef PS2_CAPS_LOCK_EN
            caps      <= 1'b0;
`endif
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_next;
            read_prev <= read_data;
            lshift    <= lshift_next;
            rshift    <= rshift_next;
`ifdef PS2_CAPS_LOCK_EN
            caps      <= caps_next;
`endif
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && !wr_en) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_char;
    end

endmodule

// File: tb/tb_ps2_ascii_decoder.sv
// Directed bench for ps2_ascii_decoder: a vector table plus hand-written multi-cycle sequences.
// Build with PS2_CAPS_LOCK_EN defined to exercise the caps-lock sequence instead of the 0x58 drop check.
module tb_ps2_ascii_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       read_data = 1'b0;
    logic       ascii_ready = 1'b0;
    logic [7:0] ascii_data;
    logic       ascii_valid;
    logic [3:0] fifo_count;
    logic       overflow;
    logic       shift_active;

    int vectors = 0;
    int miscompares = 0;

    ps2_ascii_decoder #(.FIFO_DEPTH(8)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .read_data(read_data),
        .ascii_data(ascii_data), .ascii_valid(ascii_valid), .ascii_ready(ascii_ready),
        .fifo_count(fifo_count), .overflow(overflow), .shift_active(shift_active)
    );

    always #5 clk = ~clk;

    typedef enum logic [1:0] {OP_BYTE, OP_POP} op_t;
    typedef struct {
        op_t        op;
        logic [7:0] b;
        logic [7:0] d;
        logic       v;
        logic [3:0] c;
        logic       s;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(op_t op, logic [7:0] b, logic [7:0] d, logic v, logic [3:0] c,
                                logic s);
        vec_t e;
        e.op = op; e.b = b; e.d = d; e.v = v; e.c = c; e.s = s;
        tbl.push_back(e);
    endfunction

    task automatic check(input string name, input logic [7:0] d, input logic v,
                         input logic [3:0] c, input logic s, input logic o);
        vectors++;
        if (ascii_data !== d || ascii_valid !== v || fifo_count !== c ||
            shift_active !== s || overflow !== o) begin
            miscompares++;
            $display("FAIL %s: got data=%h valid=%b count=%0d shift=%b ovf=%b, want data=%h valid=%b count=%0d shift=%b ovf=%b",
                     name, ascii_data, ascii_valid, fifo_count, shift_active, overflow,
                     d, v, c, s, o);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        read_data = 1'b1;
        @(negedge clk);
        read_data = 1'b0;
    endtask

    task automatic pop_one();
        @(negedge clk);
        ascii_ready = 1'b1;
        @(negedge clk);
        ascii_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    logic [7:0] exp_chars [8];

    initial begin
        // Table: ready held low except on pop rows; expectations seen right after each step.
        add(OP_BYTE, 8'h1C, 8'h61, 1, 1, 0);
        add(OP_BYTE, 8'hF0, 8'h61, 1, 1, 0);
        add(OP_BYTE, 8'h1C, 8'h61, 1, 1, 0);
        add(OP_POP,  8'h00, 8'h00, 0, 0, 0);
        add(OP_BYTE, 8'h12, 8'h00, 0, 0, 1);
        add(OP_BYTE, 8'h1C, 8'h41, 1, 1, 1);
        add(OP_BYTE, 8'hF0, 8'h41, 1, 1, 1);
        add(OP_BYTE, 8'h1C, 8'h41, 1, 1, 1);
        add(OP_BYTE, 8'hF0, 8'h41, 1, 1, 1);
        add(OP_BYTE, 8'h12, 8'h41, 1, 1, 0);
        add(OP_POP,  8'h00, 8'h00, 0, 0, 0);
        add(OP_BYTE, 8'hE0, 8'h00, 0, 0, 0);
        add(OP_BYTE, 8'h5A, 8'h0D, 1, 1, 0);
        add(OP_POP,  8'h00, 8'h00, 0, 0, 0);
        add(OP_BYTE, 8'hE0, 8'h00, 0, 0, 0);
        add(OP_BYTE, 8'hF0, 8'h00, 0, 0, 0);
        add(OP_BYTE, 8'h5A, 8'h00, 0, 0, 0);
        add(OP_BYTE, 8'hE0, 8'h00, 0, 0, 0);
        add(OP_BYTE, 8'h75, 8'h00, 0, 0, 0);
        add(OP_BYTE, 8'h59, 8'h00, 0, 0, 1);
        add(OP_BYTE, 8'h16, 8'h21, 1, 1, 1);
        add(OP_BYTE, 8'h4E, 8'h21, 1, 2, 1);
        add(OP_POP,  8'h00, 8'h5F, 1, 1, 1);
        add(OP_BYTE, 8'hF0, 8'h5F, 1, 1, 1);
        add(OP_BYTE, 8'h59, 8'h5F, 1, 1, 0);
        add(OP_BYTE, 8'h29, 8'h5F, 1, 2, 0);
        add(OP_POP,  8'h00, 8'h20, 1, 1, 0);
        add(OP_POP,  8'h00, 8'h00, 0, 0, 0);
        add(OP_BYTE, 8'h66, 8'h08, 1, 1, 0);
        add(OP_POP,  8'h00, 8'h00, 0, 0, 0);
        add(OP_BYTE, 8'hAA, 8'h00, 0, 0, 0);
        add(OP_BYTE, 8'h1C, 8'h61, 1, 1, 0);
        add(OP_BYTE, 8'h1C, 8'h61, 1, 2, 0);
        add(OP_POP,  8'h00, 8'h61, 1, 1, 0);
        add(OP_POP,  8'h00, 8'h00, 0, 0, 0);
        add(OP_BYTE, 8'h0D, 8'h09, 1, 1, 0);
        add(OP_BYTE, 8'h76, 8'h09, 1, 2, 0);
        add(OP_BYTE, 8'h45, 8'h09, 1, 3, 0);
        add(OP_POP,  8'h00, 8'h1B, 1, 2, 0);
        add(OP_POP,  8'h00, 8'h30, 1, 1, 0);
        add(OP_POP,  8'h00, 8'h00, 0, 0, 0);

        #12;
        check("reset_state", 8'h00, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].op == OP_BYTE) send_byte(tbl[i].b);
            else pop_one();
            check($sformatf("vec%0d", i), tbl[i].d, tbl[i].v, tbl[i].c, tbl[i].s, 1'b0);
        end

        // Latency: nothing before the taking edge, entry visible right after it.
        @(negedge clk);
        rx_data = 8'h1C;
        read_data = 1'b1;
        check("pre_edge_empty", 8'h00, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        check("post_edge_valid", 8'h61, 1, 1, 0, 0);
        // A level held high for several cycles is a single byte.
        @(negedge clk);
        rx_data = 8'h16;
        repeat (3) @(negedge clk);
        read_data = 1'b0;
        check("held_level_once", 8'h61, 1, 1, 0, 0);
        pop_one();
        check("held_level_drain", 8'h00, 0, 0, 0, 0);

        // Reset after a break prefix: the following 1C is a fresh make.
        send_byte(8'hF0);
        pulse_reset();
        send_byte(8'h1C);
        check("reset_mid_break", 8'h61, 1, 1, 0, 0);
        pulse_reset();
        check("reset_clears_fifo", 8'h00, 0, 0, 0, 0);

        // Overflow: nine pushes into eight slots, then drain exactly eight.
        for (int i = 0; i < 9; i++) send_byte(8'h16);
        check("overflow_full", 8'h31, 1, 8, 0, 1);
        @(negedge clk);
        ascii_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("overflow_drain%0d", i), 8'h31, 1, 4'(8 - i), 0, 1);
            @(negedge clk);
        end
        ascii_ready = 1'b0;
        check("overflow_drained", 8'h00, 0, 0, 0, 1);
        pulse_reset();
        check("overflow_cleared", 8'h00, 0, 0, 0, 0);

        // Full FIFO with simultaneous push and pop; drain checks order across the wrap.
        send_byte(8'h16); send_byte(8'h1E); send_byte(8'h26); send_byte(8'h25);
        send_byte(8'h2E); send_byte(8'h36); send_byte(8'h3D); send_byte(8'h3E);
        check("fill_eight", 8'h31, 1, 8, 0, 0);
        @(negedge clk);
        rx_data = 8'h46;
        read_data = 1'b1;
        ascii_ready = 1'b1;
        @(negedge clk);
        read_data = 1'b0;
        ascii_ready = 1'b0;
        check("full_push_pop", 8'h32, 1, 8, 0, 0);
        exp_chars = '{8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        ascii_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("wrap_drain%0d", i), exp_chars[i], 1, 4'(8 - i), 0, 0);
            @(negedge clk);
        end
        ascii_ready = 1'b0;
        check("wrap_drained", 8'h00, 0, 0, 0, 0);

`ifdef PS2_CAPS_LOCK_EN
        send_byte(8'h58);
        send_byte(8'h1C);
        check("caps_upper", 8'h41, 1, 1, 0, 0);
        pop_one();
        send_byte(8'h12);
        send_byte(8'h1C);
        check("caps_shift_lower", 8'h61, 1, 1, 1, 0);
        pop_one();
        send_byte(8'h58);
        send_byte(8'h1C);
        check("caps_off_shift_upper", 8'h41, 1, 1, 1, 0);
        pop_one();
        send_byte(8'hF0);
        send_byte(8'h58);
        send_byte(8'hF0);
        send_byte(8'h12);
        send_byte(8'h1C);
        check("caps_off_lower", 8'h61, 1, 1, 0, 0);
        pop_one();
        send_byte(8'h16);
        check("caps_digit_unshifted", 8'h31, 1, 1, 0, 0);
        pop_one();
`else
        send_byte(8'h58);
        check("no_caps_58_dropped", 8'h00, 0, 0, 0, 0);
        send_byte(8'h1C);
        check("no_caps_lower", 8'h61, 1, 1, 0, 0);
        pop_one();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
